// File: rtl/recieve_send_if.sv
// recieve_send_if: serial pins between an SPI master and the command port slave.
interface recieve_send_if;
    logic mosi;
    logic cs;
    logic miso;
    modport master (output mosi, output cs, input miso);
    modport slave (input mosi, input cs, output miso);
endinterface

// File: rtl/recieve_send.sv
// recieve_send: SPI-style slave that shifts in a command byte and shifts out a status byte.
module recieve_send (
    input  logic               clk,
    input  logic               rst,
    recieve_send_if.slave      spi,
    output logic               rdy,
    output logic               dn,
    output logic [3:0]         lds,
    output logic               start,
    output logic               speed
);
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
    state_t state, nxt;
    logic [7:0] rx_sr, tx_sr, b;
    logic [2:0] cnt;
    assign b = {rx_sr[6:0], spi.mosi};
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= nxt;
    always_comb begin
        nxt = spi.cs ? IDLE : state == IDLE ? SHIFT : (state == SHIFT && cnt == 3'd7) ? HOLD : state;
        rdy = state == IDLE;
        spi.miso = (!spi.cs && state != HOLD) ? tx_sr[7] : 1'b0;
    end
    // cnt is forced to 1 on a frame start so a stale count left by an abort never leaks in
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            rx_sr <= '0;
            tx_sr <= '0;
            cnt <= '0;
            dn <= 1'b0;
            lds <= '0;
            start <= 1'b0;
            speed <= 1'b0;
        end else begin
            dn <= 1'b0;
            if (state == IDLE && spi.cs) begin
                tx_sr <= {2'b10, start, speed, lds};
                cnt <= '0;
            end else if (!spi.cs && state != HOLD) begin
                rx_sr <= b;
                tx_sr <= {tx_sr[6:0], 1'b0};
                cnt <= state == IDLE ? 3'd1 : cnt + 3'd1;
                if (state == SHIFT && cnt == 3'd7) begin
                    dn <= 1'b1;
                    if (b[7:6] == 2'b01) {start, speed, lds} <= b[5:0];
                    else if (b[7:6] == 2'b10) {start, speed, lds} <= '0;
                end
            end
        end
endmodule

// File: tb/tb_recieve_send.sv
// tb_recieve_send: randomized and directed frames checked against a bit-counting model.
module tb_recieve_send;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy, dn, start, speed;
    logic [3:0] lds;
    int checks = 0;
    int failures = 0;
    recieve_send_if bus ();
    recieve_send dut (.clk(clk), .rst(rst), .spi(bus), .rdy(rdy), .dn(dn), .lds(lds), .start(start), .speed(speed));
    always #5 clk = ~clk;

    int m_bits;
    logic [7:0] m_byte, m_stat;
    logic [3:0] m_lds;
    logic m_start, m_speed, m_dn;

    // a frame is simply the first eight samples taken while cs stays low
    always @(posedge clk or negedge rst)
        if (!rst) begin
            m_bits = 0; m_byte = 0; m_stat = 0; m_lds = 0; m_start = 0; m_speed = 0; m_dn = 0;
        end else begin
            m_dn = 0;
            if (bus.cs) begin
                if (m_bits == 0) m_stat = {2'b10, m_start, m_speed, m_lds};
                m_bits = 0;
            end else if (m_bits < 8) begin
                m_byte = {m_byte[6:0], bus.mosi};
                m_bits++;
                if (m_bits == 8) begin
                    m_dn = 1;
                    if (m_byte[7:6] == 2'b01) {m_start, m_speed, m_lds} = m_byte[5:0];
                    else if (m_byte[7:6] == 2'b10) {m_start, m_speed, m_lds} = 6'd0;
                end
            end
        end

    function automatic logic exp_miso();
        return (!bus.cs && m_bits < 8) ? m_stat[7 - m_bits] : 1'b0;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk); #1;
        chk("rdy", {7'd0, rdy}, {7'd0, m_bits == 0});
        chk("dn", {7'd0, dn}, {7'd0, m_dn});
        chk("ctrl", {2'b0, start, speed, lds}, {2'b0, m_start, m_speed, m_lds});
        chk("miso_pe", {7'd0, bus.miso}, {7'd0, exp_miso()});
        @(negedge clk); #1;
        chk("miso_ne", {7'd0, bus.miso}, {7'd0, exp_miso()});
    end

    task automatic send(input logic [7:0] b, input int nb, input int extra, input int gap,
                        output logic [7:0] rb, output int dns);
        rb = 0;
        dns = 0;
        for (int i = 0; i < nb + extra; i++) begin
            @(negedge clk);
            bus.cs = 1'b0;
            bus.mosi = (i < nb) ? b[3'(7 - i)] : 1'b1;
            #1 if (i < 8) rb[3'(7 - i)] = bus.miso;
            @(posedge clk); #1 if (dn) dns++;
        end
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            bus.cs = 1'b1;
            @(posedge clk); #1 if (dn) dns++;
        end
    endtask

    logic [7:0] rb;
    int dns;
    initial begin
        bus.cs = 1'b1;
        bus.mosi = 1'b0;
        #2;
        chk("rst_ctrl", {2'b0, start, speed, lds}, 8'h00);
        chk("rst_rdy", {7'd0, rdy}, 8'h01);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        send(8'h7A, 8, 0, 2, rb, dns);
        chk("wr_ctrl", {2'b0, start, speed, lds}, 8'h3A);
        chk("wr_dn", 8'(dns), 8'd1);
        send(8'h00, 8, 0, 2, rb, dns);
        chk("readback", rb, 8'hBA);
        chk("nop_ctrl", {2'b0, start, speed, lds}, 8'h3A);
        chk("nop_dn", 8'(dns), 8'd1);
        send(8'h80, 8, 0, 2, rb, dns);
        chk("clr_ctrl", {2'b0, start, speed, lds}, 8'h00);
        chk("clr_dn", 8'(dns), 8'd1);
        send(8'hC5, 8, 0, 2, rb, dns);
        chk("rsv_ctrl", {2'b0, start, speed, lds}, 8'h00);
        chk("rsv_dn", 8'(dns), 8'd1);
        send(8'h4F, 5, 0, 2, rb, dns);
        chk("abort_dn", 8'(dns), 8'd0);
        chk("abort_ctrl", {2'b0, start, speed, lds}, 8'h00);
        chk("abort_rdy", {7'd0, rdy}, 8'h01);
        send(8'h43, 8, 0, 2, rb, dns);
        chk("post_abort_lds", {4'd0, lds}, 8'h03);
        send(8'hFF, 8, 592, 2, rb, dns);
        chk("long_dn", 8'(dns), 8'd1);
        chk("long_ctrl", {2'b0, start, speed, lds}, 8'h03);
        for (int k = 0; k < 60; k++)
            send(8'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8,
                 $urandom_range(0, 3), $urandom_range(2, 4), rb, dns);
        send(8'h7F, 8, 0, 2, rb, dns);
        @(negedge clk);
        bus.cs = 1'b0;
        bus.mosi = 1'b1;
        repeat (3) @(negedge clk);
        #3 rst = 1'b0;
        #1;
        chk("mid_rst_ctrl", {2'b0, start, speed, lds}, 8'h00);
        chk("mid_rst_flags", {5'd0, rdy, dn, bus.miso}, 8'h04);
        @(negedge clk);
        bus.cs = 1'b1;
        #3 rst = 1'b1;
        repeat (2) @(negedge clk);
        send(8'h55, 8, 0, 2, rb, dns);
        chk("after_rst_lds", {2'b0, start, speed, lds}, 8'h15);
        chk("after_rst_rb", rb, 8'h80);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
